// File: rtl/lsu_mem_adapter_if.sv
`default_nettype none
// ============================================================================
// lsu_mem_adapter_if : LSU request/response and data-memory port bundle
// Revision 1.0
// ============================================================================
interface lsu_mem_adapter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Adapter side: consumes pipeline requests and memory read data.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );

    // Pipeline plus memory side.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_adapter.sv
`default_nettype none
// ============================================================================
// lsu_mem_adapter : RISC-V load/store unit to word-wide synchronous memory
//                   adapter with sub-word extraction and read-modify-write.
// Revision 1.0
// ============================================================================
module lsu_mem_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_WORDS  = 128
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    lsu_mem_adapter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_MERGE  = 3'd2,
        S_LD_RSP = 3'd3,
        S_WR     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_num_words = ADDR_WIDTH'(NUM_WORDS);
    localparam logic [2:0] c_f3_b  = 3'd0;
    localparam logic [2:0] c_f3_h  = 3'd1;
    localparam logic [2:0] c_f3_w  = 3'd2;
    localparam logic [2:0] c_f3_bu = 3'd4;
    localparam logic [2:0] c_f3_hu = 3'd5;

    state_t                r_state;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wbuf;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_mem_ren;
    logic                  r_mem_wen;

    logic [ADDR_WIDTH-1:0] w_req_idx;
    logic                  w_req_err;
    logic [4:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_lane;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_req_idx = {2'b00, bus.req_addr[ADDR_WIDTH-1:2]};

    always_comb begin
        w_req_err = 1'b0;
        if (bus.req_we) begin
            if (bus.req_funct3 > c_f3_w) w_req_err = 1'b1;
        end else begin
            if (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 || bus.req_funct3 == 3'd7)
                w_req_err = 1'b1;
        end
        if (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) w_req_err = 1'b1;
        if (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0) w_req_err = 1'b1;
        if (w_req_idx >= c_num_words) w_req_err = 1'b1;
    end

    // Aligned accesses only reach here, so one byte-granular shift serves every width.
    assign w_shamt = {r_addr[1:0], 3'b000};
    assign w_lane  = bus.mem_rdata >> w_shamt;

    always_comb begin
        case (r_funct3)
            c_f3_b:  w_ext = {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
            c_f3_h:  w_ext = {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
            c_f3_bu: w_ext = {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]};
            c_f3_hu: w_ext = {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

    assign w_mask   = (r_funct3[0] ? DATA_WIDTH'(16'hFFFF) : DATA_WIDTH'(8'hFF)) << w_shamt;
    assign w_merged = (bus.mem_rdata & ~w_mask) | ((r_wbuf << w_shamt) & w_mask);

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = (r_state == S_LD_RSP) ? w_ext : '0;
    assign bus.mem_ren   = r_mem_ren;
    assign bus.mem_wen   = r_mem_wen;
    assign bus.mem_raddr = {2'b00, r_addr[ADDR_WIDTH-1:2]};
    assign bus.mem_waddr = {2'b00, r_addr[ADDR_WIDTH-1:2]};
    assign bus.mem_wdata = r_mem_wen ? r_wbuf : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= '0;
            r_wbuf      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wbuf   <= bus.req_wdata;
                        if (w_req_err) begin
                            r_state     <= S_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (bus.req_we && bus.req_funct3 == c_f3_w) begin
                            r_state     <= S_WR;
                            r_mem_wen   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state   <= S_RD;
                            r_mem_ren <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (r_we) begin
                        r_state <= S_MERGE;
                    end else begin
                        r_state     <= S_LD_RSP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_MERGE: begin
                    r_wbuf      <= w_merged;
                    r_state     <= S_WR;
                    r_mem_wen   <= 1'b1;
                    r_rsp_valid <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_adapter.sv
`default_nettype none
// ============================================================================
// tb_lsu_mem_adapter : directed self-checking bench for lsu_mem_adapter
// Revision 1.0
// ============================================================================
module tb_lsu_mem_adapter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int wen_cnt = 0;
    int ren_cnt = 0;
    int rv_cnt  = 0;

    logic [31:0] mem [0:127];
    logic        pre_en   = 1'b0;
    logic [6:0]  pre_idx  = '0;
    logic [31:0] pre_data = '0;

    lsu_mem_adapter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    lsu_mem_adapter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .NUM_WORDS (128)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous word memory with one-cycle registered read.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        else if (bus.mem_wen) mem[bus.mem_waddr[6:0]] <= bus.mem_wdata;
        if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_raddr[6:0]];
        if (bus.mem_wen)   wen_cnt <= wen_cnt + 1;
        if (bus.mem_ren)   ren_cnt <= ren_cnt + 1;
        if (bus.rsp_valid) rv_cnt  <= rv_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] data);
        pre_idx  = idx;
        pre_data = data;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_wen, bus.mem_ren} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_wen, bus.mem_ren});
        end
        checks++;
        if ({bus.rsp_rdata, bus.mem_wdata, bus.mem_waddr, bus.mem_raddr} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0",
                     {bus.rsp_rdata, bus.mem_wdata, bus.mem_waddr, bus.mem_raddr});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sw();
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({bus.mem_wen, bus.rsp_valid, bus.rsp_err, bus.mem_ren} !== 4'b1100) begin
            errors++;
            $display("FAIL sw_ctrl got %b want 1100",
                     {bus.mem_wen, bus.rsp_valid, bus.rsp_err, bus.mem_ren});
        end
        checks++;
        if (bus.mem_waddr !== 32'd4 || bus.mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_data got waddr=%h wdata=%h want 4 deadbeef", bus.mem_waddr, bus.mem_wdata);
        end
        tick();
        checks++;
        if ({bus.req_ready, bus.mem_wen, bus.rsp_valid} !== 3'b100 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL sw_idle got rdy/wen/rv=%b wdata=%h want 100 0",
                     {bus.req_ready, bus.mem_wen, bus.rsp_valid}, bus.mem_wdata);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_mem got %h want deadbeef", mem[4]);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0, 3'd4};
        logic [31:0] adrs [7] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h10, 32'h11};
        logic [31:0] exps [7] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB,
                                  32'h8899AABB, 32'hFFFFFFBB, 32'h000000AA};
        preload(7'd4, 32'h8899AABB);
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'hFFFF_FFFF);
            checks++;
            if ({bus.mem_ren, bus.rsp_valid, bus.req_ready} !== 3'b100 || bus.mem_raddr !== 32'd4) begin
                errors++;
                $display("FAIL load%0d_rd got ren/rv/rdy=%b raddr=%h want 100 4",
                         i, {bus.mem_ren, bus.rsp_valid, bus.req_ready}, bus.mem_raddr);
            end
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== exps[i]) begin
                errors++;
                $display("FAIL load%0d_rsp got rv=%b err=%b rdata=%h want 1 0 %h",
                         i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, exps[i]);
            end
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL load%0d_idle got rv=%b rdata=%h rdy=%b want 0 0 1",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
            end
        end
    endtask

    task automatic test_rmw();
        logic [2:0]  f3s  [2] = '{3'd0, 3'd1};
        logic [31:0] adrs [2] = '{32'h11, 32'h12};
        logic [31:0] wds  [2] = '{32'h12345677, 32'h0000CAFE};
        logic [31:0] exps [2] = '{32'hDEAD77EF, 32'hCAFEBEEF};
        for (int i = 0; i < 2; i++) begin
            preload(7'd4, 32'hDEADBEEF);
            issue(1'b1, f3s[i], adrs[i], wds[i]);
            // Inputs change while busy; the latched request must win.
            bus.req_addr  = 32'h0;
            bus.req_wdata = 32'h0;
            checks++;
            if ({bus.mem_ren, bus.mem_wen, bus.rsp_valid} !== 3'b100) begin
                errors++;
                $display("FAIL rmw%0d_rd got ren/wen/rv=%b want 100", i,
                         {bus.mem_ren, bus.mem_wen, bus.rsp_valid});
            end
            tick();
            checks++;
            if ({bus.mem_ren, bus.mem_wen, bus.rsp_valid, bus.req_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL rmw%0d_merge got ren/wen/rv/rdy=%b want 0000", i,
                         {bus.mem_ren, bus.mem_wen, bus.rsp_valid, bus.req_ready});
            end
            tick();
            checks++;
            if ({bus.mem_wen, bus.rsp_valid, bus.rsp_err} !== 3'b110 ||
                bus.mem_wdata !== exps[i] || bus.mem_waddr !== 32'd4) begin
                errors++;
                $display("FAIL rmw%0d_wr got wen/rv/err=%b wdata=%h waddr=%h want 110 %h 4", i,
                         {bus.mem_wen, bus.rsp_valid, bus.rsp_err}, bus.mem_wdata, bus.mem_waddr, exps[i]);
            end
            tick();
            checks++;
            if (bus.req_ready !== 1'b1 || mem[4] !== exps[i]) begin
                errors++;
                $display("FAIL rmw%0d_done got rdy=%b mem=%h want 1 %h", i, bus.req_ready, mem[4], exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [5] = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] adrs [5] = '{32'h06, 32'h05, 32'h200, 32'h00, 32'h00};
        int ren0;
        int wen0;
        ren0 = ren_cnt;
        wen0 = wen_cnt;
        for (int i = 0; i < 5; i++) begin
            issue(wes[i], f3s[i], adrs[i], 32'h5555_5555);
            checks++;
            if ({bus.rsp_valid, bus.rsp_err, bus.mem_ren, bus.mem_wen} !== 4'b1100 ||
                bus.rsp_rdata !== 32'h0 || bus.mem_wdata !== 32'h0) begin
                errors++;
                $display("FAIL err%0d got rv/err/ren/wen=%b rdata=%h wdata=%h want 1100 0 0", i,
                         {bus.rsp_valid, bus.rsp_err, bus.mem_ren, bus.mem_wen}, bus.rsp_rdata, bus.mem_wdata);
            end
            tick();
            checks++;
            if ({bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 3'b001) begin
                errors++;
                $display("FAIL err%0d_idle got rv/err/rdy=%b want 001", i,
                         {bus.rsp_valid, bus.rsp_err, bus.req_ready});
            end
        end
        checks++;
        if (ren_cnt != ren0 || wen_cnt != wen0) begin
            errors++;
            $display("FAIL err_mem_quiet got ren=%0d wen=%0d want 0 0", ren_cnt - ren0, wen_cnt - wen0);
        end
        // Last word in range is still legal.
        preload(7'd127, 32'h12345678);
        issue(1'b0, 3'd2, 32'h1FC, 32'h0);
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL lw_last got rv=%b err=%b rdata=%h want 1 0 12345678",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int wen0;
        int rv0;
        preload(7'd4, 32'hDEADBEEF);
        wen0 = wen_cnt;
        rv0  = rv_cnt;
        issue(1'b1, 3'd0, 32'h11, 32'h55);
        tick();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_wen, bus.mem_ren} !== 5'b10000 ||
            {bus.rsp_rdata, bus.mem_wdata, bus.mem_waddr, bus.mem_raddr} !== 128'h0) begin
            errors++;
            $display("FAIL rstmid_async got ctrl=%b data=%h want 10000 0",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_wen, bus.mem_ren},
                     {bus.rsp_rdata, bus.mem_wdata, bus.mem_waddr, bus.mem_raddr});
        end
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h10;
        bus.req_valid  = 1'b1;
        tick();
        checks++;
        if ({bus.req_ready, bus.mem_ren, bus.mem_wen, bus.rsp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL rstmid_held got rdy/ren/wen/rv=%b want 1000",
                     {bus.req_ready, bus.mem_ren, bus.mem_wen, bus.rsp_valid});
        end
        rst_n = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.req_ready, bus.mem_ren} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_accept got rdy/ren=%b want 01", {bus.req_ready, bus.mem_ren});
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rstmid_lw got rv=%b err=%b rdata=%h want 1 0 deadbeef",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        tick();
        checks++;
        if (wen_cnt != wen0 || rv_cnt - rv0 != 1 || mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rstmid_abandon got wen=%0d rv=%0d mem=%h want 0 1 deadbeef",
                     wen_cnt - wen0, rv_cnt - rv0, mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        int rv0;
        preload(7'd4, 32'h0BADF00D);
        rv0 = rv_cnt;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h10;
        bus.req_valid  = 1'b1;
        tick();
        checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_ren !== 1'b1) begin
            errors++;
            $display("FAIL b2b_t1 got rdy=%b ren=%b want 0 1", bus.req_ready, bus.mem_ren);
        end
        tick();
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL b2b_t2 got rdy=%b rv=%b rdata=%h want 0 1 0badf00d",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
        end
        tick();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_t3 got rdy=%b rv=%b want 1 0", bus.req_ready, bus.rsp_valid);
        end
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_ren !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got rdy=%b ren=%b want 0 1", bus.req_ready, bus.mem_ren);
        end
        repeat (4) tick();
        checks++;
        if (rv_cnt - rv0 != 2) begin
            errors++;
            $display("FAIL b2b_pulses got %0d want 2", rv_cnt - rv0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        test_reset();
        test_sw();
        test_loads();
        test_rmw();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
